// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and wait-counter width.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  // Large enough to hold MEM_LATENCY-1 for latencies up to 7.
  localparam int ARB_CNT_W = 3;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping
// modulo NUM_REQ. Returns the one-hot grant, its index and whether anything won.
module rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] cand_idx;

  // NOTE: every output gets a default before the loop, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr_i} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      cand_idx = cand[IDX_W-1:0];
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory data port among NUM_REQ requesters;
// one transaction at a time through IDLE -> ISSUE -> (WAIT) -> RESP.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_we,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     id_q, id_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        // In IDLE req_ready equals the picker grant, so a winner is an accept.
        if (pick_any) begin
          id_d    = pick_idx;
          we_d    = req_we[pick_idx];
          addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[pick_idx*DATA_W +: DATA_W];
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (we_q) begin
          rdata_d = '0;
          state_d = ARB_RESP;
        end else begin
          cnt_d   = ARB_CNT_W'(MEM_LATENCY - 1);
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          state_d = ARB_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ARB_RESP: begin
        rr_ptr_d = (id_q == IDX_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // Ready is masked during reset so no handshake appears on an edge that cannot accept.
  assign req_ready = (state_q == ARB_IDLE && !reset) ? pick_gnt : '0;
  assign rsp_valid = (state_q == ARB_RESP) ? (NUM_REQ'(1) << id_q) : '0;
  assign rsp_rdata = rdata_q;
  assign mem_addr  = (state_q == ARB_ISSUE || state_q == ARB_WAIT) ? addr_q : '0;
  assign mem_wdata = (state_q == ARB_ISSUE) ? wdata_q : '0;
  assign mem_we    = (state_q == ARB_ISSUE) && we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares each rsp_valid strobe.
module tb_mem_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Small word-addressed memory behind the port.
  logic [DW-1:0] mem_arr [0:63];
  assign mem_rdata = mem_arr[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [N-1:0]  onehot;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_note(input string name);
    n_total++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Monitor: every response strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL rsp_unexpected: got rsp_valid=%b expected none (cycle %0d)", rsp_valid, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_onehot", 64'(rsp_valid), 64'(e.onehot));
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_grant(output int gc);
    bit ok;
    ok = 1'b0;
    gc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        ok = 1'b1;
        gc = cyc;
        break;
      end
    end
    if (!ok) fail_note("grant_timeout");
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic push_exp(input logic [N-1:0] oh, input logic [DW-1:0] rd, input int at);
    exp_t e;
    e.onehot = oh;
    e.rdata  = rd;
    e.cyc    = at;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i]               = we;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*DW +: DW]   = d;
    req_valid[i]            = 1'b1;
  endtask

  // One isolated transaction; rd_exp is the hand-computed read result.
  task automatic single(input int i, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] rd_exp,
                        input logic [N-1:0] exp_ready);
    int gc;
    @(posedge clk); #1;
    set_req(i, we, a, d);
    wait_grant(gc);
    check("single_ready", 64'(req_ready), 64'(exp_ready));
    push_exp(exp_ready, we ? '0 : rd_exp, gc + 2 + (we ? 0 : LAT));
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    @(negedge clk);
    check("issue_addr", 64'(mem_addr), 64'(a));
    check("issue_we", 64'(mem_we), 64'(we));
    if (we) check("issue_wdata", 64'(mem_wdata), 64'(d));
    else begin
      for (int w = 0; w < LAT; w++) begin
        @(negedge clk);
        check("wait_we", 64'(mem_we), 64'd0);
        check("wait_addr", 64'(mem_addr), 64'(a));
      end
    end
    drain();
  endtask

  initial begin
    int gc, prev_gc;
    logic [N-1:0] expv;
    foreach (mem_arr[k]) mem_arr[k] = '0;
    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Quiet after reset: nothing may move.
    repeat (10) begin
      @(negedge clk);
      check("idle_outputs",
            64'({req_ready, rsp_valid, mem_we, rsp_rdata != '0, mem_addr != '0, mem_wdata != '0}),
            64'd0);
    end

    // Requester 2 writes, then requester 1 reads the same word back.
    single(2, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0, 4'b0100);
    single(1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 4'b0010);

    // Requester 0 read aborted by reset while waiting on memory.
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h40, 32'h0);
    wait_grant(gc);
    check("abort_ready", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("abort_issue_we", 64'(mem_we), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i));
    @(negedge clk);
    check("reset_ready_masked", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("after_reset_outputs",
          64'({req_ready, rsp_valid, mem_we, rsp_rdata != '0, mem_addr != '0, mem_wdata != '0}),
          64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // All four valid from reset: grants 0,1,2,3,0 spaced ISSUE+RESP+IDLE apart.
    prev_gc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(gc);
      expv = 4'b0001 << (k % N);
      check("all_valid_grant", 64'(req_ready), 64'(expv));
      if (k > 0) check("all_valid_spacing", 64'(gc), 64'(prev_gc + 3));
      push_exp(expv, '0, gc + 2);
      prev_gc = gc;
      @(posedge clk); #1;
      if (k == 4) req_valid = '0;
    end
    drain();

    // Move rr_ptr to 3, then 1 and 3 together: 3 wins, then 1 by wrap.
    single(2, 1'b1, 32'h80, 32'h22, 32'h0, 4'b0100);
    @(posedge clk); #1;
    set_req(1, 1'b1, 32'h84, 32'h11);
    set_req(3, 1'b1, 32'h88, 32'h33);
    wait_grant(gc);
    check("wrap_first", 64'(req_ready), 64'(4'b1000));
    push_exp(4'b1000, '0, gc + 2);
    prev_gc = gc;
    @(posedge clk); #1 req_valid[3] = 1'b0;
    wait_grant(gc);
    check("wrap_second", 64'(req_ready), 64'(4'b0010));
    check("wrap_spacing", 64'(gc), 64'(prev_gc + 3));
    push_exp(4'b0010, '0, gc + 2);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    drain();

    // rr_ptr should now be 2: with 0 and 2 valid, 2 wins first.
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'h90, 32'h5);
    set_req(2, 1'b1, 32'h94, 32'h6);
    wait_grant(gc);
    check("ptr2_first", 64'(req_ready), 64'(4'b0100));
    push_exp(4'b0100, '0, gc + 2);
    @(posedge clk); #1 req_valid[2] = 1'b0;
    wait_grant(gc);
    check("ptr2_second", 64'(req_ready), 64'(4'b0001));
    push_exp(4'b0001, '0, gc + 2);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
